// File: rtl/brp_pkg.sv
// Shared definitions for the branch resolve unit.
//   PC_W         default PC/target width
//   brp_state_t  RUN / FLUSH control state
//   upd_entry_t  one BTB update record {pc, target}
//   sat_inc16    16-bit saturating increment used by the statistics counters
package brp_pkg;

    localparam int PC_W = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } brp_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } upd_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/upd_fifo.sv
// Small register-based FIFO holding pending BTB updates.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   push, push_data        append an entry (ignored while full, even if popping)
//   ovr, ovr_data          overwrite the newest (tail) entry in place
//   pop                    drop the head entry (ignored while empty)
//   head_data              current head entry
//   tail_key               upper KEY_W bits of the newest entry (coalescing key)
//   empty, full            occupancy flags
//   tail_is_head           exactly one entry held (tail and head are the same slot)
module upd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int KEY_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ovr,
    input  logic [DATA_W-1:0] ovr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [KEY_W-1:0]  tail_key,
    output logic              empty,
    output logic              full,
    output logic              tail_is_head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]       rd_ptr_reg, wr_ptr_reg;
    logic [AW-1:0]     rd_idx, wr_idx, tail_idx;
    logic              push_fire, pop_fire;
    logic [DATA_W-1:0] entry_vec [DEPTH];

    assign rd_idx       = rd_ptr_reg[AW-1:0];
    assign wr_idx       = wr_ptr_reg[AW-1:0];
    assign tail_idx     = wr_idx - AW'(1);
    assign empty        = (rd_ptr_reg == wr_ptr_reg);
    assign full         = (rd_ptr_reg[AW] != wr_ptr_reg[AW]) && (rd_idx == wr_idx);
    assign tail_is_head = ((wr_ptr_reg - rd_ptr_reg) == (AW+1)'(1));
    assign push_fire    = push && !full;
    assign pop_fire     = pop && !empty;

    // Entries are reset so the head output reads zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push_fire && (wr_idx == AW'(gi))) begin
                    entry_reg <= push_data;
                end else if (ovr && !empty && (tail_idx == AW'(gi))) begin
                    entry_reg <= ovr_data;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    assign head_data = entry_vec[rd_idx];
    assign tail_key  = entry_vec[tail_idx][DATA_W-1 -: KEY_W];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares the resolved outcome of a branch in EX with
// what fetch predicted, issues a one-cycle fetch redirect on a mispredict,
// squashes wrong-path branches for FLUSH_CYC cycles, queues BTB updates and
// keeps branch / mispredict statistics.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   ex_valid/ex_ready                   resolved branch handshake from EX
//   ex_pc, ex_taken, ex_target          resolved instruction PC, outcome, target
//   ex_pred_hit, ex_pred_pc             fetch-time BTB prediction
//   redirect_valid, redirect_pc         registered fetch redirect pulse
//   upd_valid/upd_ready                 BTB update handshake
//   upd_pc, upd_target                  BTB update contents (queue head)
//   branch_cnt, mispredict_cnt          saturating statistics
module branch_resolve_unit #(
    parameter int PC_W      = brp_pkg::PC_W,
    parameter int UPD_DEPTH = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_hit,
    input  logic [PC_W-1:0] ex_pred_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
);

    import brp_pkg::*;

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    brp_state_t        state_reg, state_next;
    logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic              redirect_valid_reg;
    logic [PC_W-1:0]   redirect_pc_reg;
    logic [15:0]       branch_cnt_reg, mispredict_cnt_reg;

    logic [PC_W-1:0]   pc_plus4, actual_next, pred_next;
    logic              accept, mispredict, need_upd, coalesce, push, pop;
    logic              q_empty, q_full, q_tail_is_head;
    logic [2*PC_W-1:0] q_head, new_entry;
    logic [PC_W-1:0]   q_tail_pc;

    assign pc_plus4    = ex_pc + PC_W'(4);
    assign actual_next = ex_taken    ? ex_target  : pc_plus4;
    assign pred_next   = ex_pred_hit ? ex_pred_pc : pc_plus4;

    // In FLUSH the unit swallows wrong-path branches, so it always looks ready.
    assign ex_ready   = (state_reg == ST_FLUSH) ? 1'b1 : !q_full;
    assign accept     = ex_valid && ex_ready && (state_reg == ST_RUN);
    assign mispredict = accept && (actual_next != pred_next);

    // Only taken branches whose BTB entry is missing or stale need an update.
    assign need_upd  = accept && ex_taken && (!ex_pred_hit || (ex_pred_pc != ex_target));
    assign pop       = !q_empty && upd_ready;
    // Coalesce into the newest entry unless that entry is the head leaving
    // this very cycle; then a fresh entry is pushed instead.
    assign coalesce  = need_upd && !q_empty && (q_tail_pc == ex_pc) && !(pop && q_tail_is_head);
    assign push      = need_upd && !coalesce;
    assign new_entry = {ex_pc, ex_target};

    upd_fifo #(
        .DEPTH  (UPD_DEPTH),
        .DATA_W (2*PC_W),
        .KEY_W  (PC_W)
    ) u_upd_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (new_entry),
        .ovr          (coalesce),
        .ovr_data     (new_entry),
        .pop          (pop),
        .head_data    (q_head),
        .tail_key     (q_tail_pc),
        .empty        (q_empty),
        .full         (q_full),
        .tail_is_head (q_tail_is_head)
    );

    assign upd_valid  = !q_empty;
    assign upd_pc     = q_head[2*PC_W-1:PC_W];
    assign upd_target = q_head[PC_W-1:0];

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Control FSM: next state. FLUSH lasts exactly FLUSH_CYC cycles.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (mispredict) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYC);
                end
            end
            ST_FLUSH: begin
                flush_cnt_next = flush_cnt_reg - FC_W'(1);
                if (flush_cnt_reg == FC_W'(1)) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // Redirect pulse and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            redirect_valid_reg <= mispredict;
            if (mispredict) begin
                redirect_pc_reg    <= actual_next;
                mispredict_cnt_reg <= sat_inc16(mispredict_cnt_reg);
            end
            if (accept) begin
                branch_cnt_reg <= sat_inc16(branch_cnt_reg);
            end
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign branch_cnt     = branch_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Expected BTB updates are pushed to a
// scoreboard queue as branches are driven and compared when the DUT drains them.
module tb_branch_resolve_unit;

    import brp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_hit;
    logic [31:0] ex_pred_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;
    upd_entry_t upd_q[$];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_hit    (ex_pred_hit),
        .ex_pred_pc     (ex_pred_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic hit, input logic [31:0] ppc);
        ex_pc       = pc;
        ex_taken    = taken;
        ex_target   = tgt;
        ex_pred_hit = hit;
        ex_pred_pc  = ppc;
    endtask

    // Presents one branch for one clock edge; returns just after that edge.
    task automatic send(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic hit, input logic [31:0] ppc);
        set_ex(pc, taken, tgt, hit, ppc);
        ex_valid = 1'b1;
        step(1);
        ex_valid = 1'b0;
        $display("txn branch pc=0x%0h taken=%0b target=0x%0h hit=%0b pred=0x%0h -> redir=%0b/0x%0h br=%0d misp=%0d",
                 pc, taken, tgt, hit, ppc, redirect_valid, redirect_pc, branch_cnt, mispredict_cnt);
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] tgt);
        upd_entry_t e;
        e.pc     = pc;
        e.target = tgt;
        upd_q.push_back(e);
    endtask

    // Accepts updates until the scoreboard and the DUT queue are both empty.
    task automatic drain(input string tag);
        upd_entry_t e;
        bit done = 0;
        upd_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (upd_valid) begin
                if (upd_q.size() == 0) begin
                    check({tag, "_extra_entry"}, 32'(upd_valid), 32'd0);
                end else begin
                    e = upd_q.pop_front();
                    $display("txn update pc=0x%0h target=0x%0h", upd_pc, upd_target);
                    check({tag, "_upd_pc"}, upd_pc, e.pc);
                    check({tag, "_upd_target"}, upd_target, e.target);
                end
            end else if (upd_q.size() == 0) begin
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        upd_ready = 1'b0;
        check({tag, "_left_in_scoreboard"}, 32'(upd_q.size()), 32'd0);
        check({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_redir_v"},  32'(redirect_valid), 32'd0);
        check({tag, "_redir_pc"}, redirect_pc, 32'd0);
        check({tag, "_upd_v"},    32'(upd_valid), 32'd0);
        check({tag, "_upd_pc"},   upd_pc, 32'd0);
        check({tag, "_upd_tgt"},  upd_target, 32'd0);
        check({tag, "_br_cnt"},   32'(branch_cnt), 32'd0);
        check({tag, "_misp_cnt"}, 32'(mispredict_cnt), 32'd0);
        check({tag, "_ex_ready"}, 32'(ex_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        upd_ready = 1'b0;
        set_ex(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(2);
        check_cleared("reset");
        rst_n = 1'b1;
        step(1);

        // Taken branch missing from the BTB: redirect, update queued.
        send(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        exp_push(32'h100, 32'h200);
        check("t1_redir_v",  32'(redirect_valid), 32'd1);
        check("t1_redir_pc", redirect_pc, 32'h200);
        check("t1_misp",     32'(mispredict_cnt), 32'd1);
        check("t1_br",       32'(branch_cnt), 32'd1);
        check("t1_upd_v",    32'(upd_valid), 32'd1);
        step(1);
        check("t1_redir_one_cycle", 32'(redirect_valid), 32'd0);
        step(1);
        drain("t1");

        // Correctly predicted taken branch: nothing but the branch count.
        send(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check("t2_redir_v", 32'(redirect_valid), 32'd0);
        check("t2_br",      32'(branch_cnt), 32'd2);
        check("t2_misp",    32'(mispredict_cnt), 32'd1);
        check("t2_upd_v",   32'(upd_valid), 32'd0);

        // Not-taken branch predicted taken: redirect to pc+4, wrong path squashed.
        send(32'h300, 1'b0, 32'h0, 1'b1, 32'h400);
        check("t3_redir_v",  32'(redirect_valid), 32'd1);
        check("t3_redir_pc", redirect_pc, 32'h304);
        check("t3_upd_v",    32'(upd_valid), 32'd0);
        check("t3_misp",     32'(mispredict_cnt), 32'd2);
        set_ex(32'h900, 1'b1, 32'hA00, 1'b0, 32'h0);
        ex_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_ready_in_flush", 32'(ex_ready), 32'd1);
            step(1);
        end
        ex_valid = 1'b0;
        check("t3_flush_br",    32'(branch_cnt), 32'd3);
        check("t3_flush_redir", 32'(redirect_valid), 32'd0);
        check("t3_flush_upd",   32'(upd_valid), 32'd0);

        // Fill the queue with four misses while the BTB stalls.
        for (int i = 0; i < 4; i++) begin
            send(32'h1000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16), 1'b0, 32'h0);
            exp_push(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
            step(2);
        end
        @(negedge clk);
        check("t4_full_not_ready", 32'(ex_ready), 32'd0);
        check("t4_head_pc",        upd_pc, 32'h1000);
        step(1);
        set_ex(32'h1040, 1'b1, 32'h2040, 1'b0, 32'h0);
        ex_valid = 1'b1;
        step(3);
        ex_valid = 1'b0;
        check("t4_fifth_held_br",    32'(branch_cnt), 32'd7);
        check("t4_fifth_held_redir", 32'(redirect_valid), 32'd0);
        drain("t4");
        @(negedge clk);
        check("t4_ready_back", 32'(ex_ready), 32'd1);
        step(1);

        // Two updates for the same PC coalesce into one entry.
        send(32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        step(2);
        send(32'h500, 1'b1, 32'h700, 1'b0, 32'h0);
        step(2);
        exp_push(32'h500, 32'h700);
        check("t5_coalesced_tgt", upd_target, 32'h700);
        drain("t5");

        // Same PC while its sole entry is being popped: a new entry is pushed.
        send(32'h700, 1'b1, 32'h800, 1'b0, 32'h0);
        step(2);
        set_ex(32'h700, 1'b1, 32'h900, 1'b0, 32'h0);
        ex_valid  = 1'b1;
        upd_ready = 1'b1;
        @(negedge clk);
        check("t6_popped_pc",  upd_pc, 32'h700);
        check("t6_popped_tgt", upd_target, 32'h800);
        step(1);
        ex_valid  = 1'b0;
        upd_ready = 1'b0;
        check("t6_new_entry_v",   32'(upd_valid), 32'd1);
        check("t6_new_entry_tgt", upd_target, 32'h900);
        exp_push(32'h700, 32'h900);
        step(2);
        drain("t6");

        // Reset in the middle of a flush with three updates queued.
        send(32'h3000, 1'b1, 32'h3800, 1'b0, 32'h0);
        step(2);
        send(32'h3100, 1'b1, 32'h3900, 1'b0, 32'h0);
        step(2);
        send(32'h3200, 1'b1, 32'h3A00, 1'b0, 32'h0);
        check("t7_pre_redir", 32'(redirect_valid), 32'd1);
        check("t7_pre_upd",   32'(upd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("t7_async");
        step(1);
        rst_n = 1'b1;
        step(1);
        upd_q.delete();
        check("t7_ready_after", 32'(ex_ready), 32'd1);
        check("t7_upd_after",   32'(upd_valid), 32'd0);
        send(32'h4000, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t7_run_br",    32'(branch_cnt), 32'd1);
        check("t7_run_redir", 32'(redirect_valid), 32'd0);
        send(32'h4100, 1'b1, 32'h4200, 1'b0, 32'h0);
        exp_push(32'h4100, 32'h4200);
        check("t7_redir_pc", redirect_pc, 32'h4200);
        check("t7_misp",     32'(mispredict_cnt), 32'd1);
        step(2);
        drain("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC/target width.
REQ-002 SHALL have parameter UPD_DEPTH, default 4, BTB update queue entries (power of 2, >=2).
REQ-003 SHALL have parameter FLUSH_CYC, default 2, wrong-path cycles squashed after a redirect (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ex_valid  in  1  resolved branch/jump present in EX.
REQ-007 SHALL have ex_ready  out  1  EX may present a branch this cycle.
REQ-008 SHALL have ex_pc  in  PC_W  PC of the resolved instruction.
REQ-009 SHALL have ex_taken  in  1  actual outcome.
REQ-010 SHALL have ex_target  in  PC_W  actual taken target.
REQ-011 SHALL have ex_pred_hit  in  1  BTB hit at fetch, carried down the pipe.
REQ-012 SHALL have ex_pred_pc  in  PC_W  predicted PC used at fetch.
REQ-013 SHALL have redirect_valid  out  1  one-cycle fetch redirect pulse.
REQ-014 SHALL have redirect_pc  out  PC_W  correct next PC.
REQ-015 SHALL have upd_valid/upd_ready  out/in  1  BTB update handshake.
REQ-016 SHALL have upd_pc, upd_target  out  PC_W each  BTB update PC and target.
REQ-017 SHALL have branch_cnt, mispredict_cnt  out  16 each  statistics.

Function
REQ-018 SHALL accept a branch when ex_valid && ex_ready && state==RUN.
REQ-019 SHALL compute actual_next = ex_taken ? ex_target : ex_pc+4 and pred_next = ex_pred_hit ? ex_pred_pc : ex_pc+4, with PC_W-bit wrap.
REQ-020 SHALL flag mispredict when actual_next != pred_next on an accepted branch.
REQ-021 SHALL register redirect: redirect_valid=1 and redirect_pc=actual_next exactly one cycle after a mispredicting accept, for one cycle only.
REQ-022 SHALL implement FSM RUN/FLUSH: a mispredict in RUN moves to FLUSH with a down-counter loaded with FLUSH_CYC; FLUSH decrements each cycle and returns to RUN on the cycle the counter reaches 1.
REQ-023 SHALL ignore ex_valid in FLUSH, with no enqueue, count, or redirect; ex_ready=1 in FLUSH.
REQ-024 SHALL drive ex_ready = !queue_full in RUN; a push is blocked when full even if a pop occurs the same cycle.
REQ-025 SHALL enqueue {ex_pc, ex_target} on an accepted branch when ex_taken && (!ex_pred_hit || ex_pred_pc != ex_target); not-taken branches never enqueue.
REQ-026 SHALL coalesce: if the queue is non-empty and the newest entry has upd_pc == ex_pc, overwrite that entry's target instead of pushing.
REQ-027 SHALL present the queue head: upd_valid = !empty; pop on upd_valid && upd_ready; head fields stable while upd_valid && !upd_ready.
REQ-028 SHALL support push and pop in the same cycle when not full, leaving the occupancy unchanged; pointers wrap modulo UPD_DEPTH.
REQ-029 SHALL never let coalescing modify the head entry while it is being popped; in that case a new push occurs instead.
REQ-030 SHALL increment branch_cnt per accepted branch and mispredict_cnt per mispredict, both saturating at 16'hFFFF.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear: state=RUN, flush counter=0, queue empty, redirect_valid=0, redirect_pc=0, upd_valid=0, upd_pc=0, upd_target=0, both counters=0.
REQ-032 SHALL discard queued updates and any pending redirect or flush when reset is asserted mid-operation; after reset, ex_ready=1.

Structure
REQ-033 SHALL place PC_W, the RUN/FLUSH state typedef, and the {pc,target} update-entry struct in the shared package brp_pkg.
REQ-034 SHALL implement the queue as the sub-module upd_fifo (parameterised depth, with tail-overwrite port).

Verification
REQ-035 SHALL test: pc=0x100, taken, target=0x200, pred_hit=0 -> redirect 0x200 next cycle; update {0x100,0x200} queued; mispredict_cnt=1.
REQ-036 SHALL test: pc=0x100, taken, target=0x200, pred_hit=1, pred_pc=0x200 -> no redirect, no enqueue, branch_cnt+1.
REQ-037 SHALL test: pc=0x300, not taken, pred_hit=1, pred_pc=0x400 -> redirect 0x304, no enqueue, ex_valid ignored for 2 cycles.
REQ-038 SHALL test: upd_ready=0 with 4 taken misses -> ex_ready=0; 5th held; upd_ready=1 -> FIFO order drains and ex_ready returns.
REQ-039 SHALL test: two consecutive pushes with pc=0x500 (targets 0x600, 0x700) and upd_ready=0 -> one entry {0x500,0x700}.
REQ-040 SHALL test: rst_n low during FLUSH with 3 entries queued -> all outputs 0, upd_valid=0, ex_ready=1 after release.
